// File: rtl/ccx_rst_seq_ctl.sv
// CCX reset / debug-init sequencer: ordered cold release of adbginit_l then rst_l, warm resets on request.
// Optional build macro CCX_RST_SYNC_EN adds 2-flop synchronizers on se_in and wrst_req.
module ccx_rst_seq_ctl #(
    parameter int HOLD_CYC = 16,
    parameter int DBG_GAP  = 4,
    parameter int CNT_W    = 8
) (
    input  logic rclk,
    input  logic rst,
    input  logic se_in,
    input  logic wrst_req,
    output logic rst_l_out,
    output logic adbginit_l_out,
    output logic se_out,
    output logic rst_done,
    output logic wrst_ack
);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_DBG_REL = 2'd1,
        ST_RUN     = 2'd2,
        ST_WRST    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBG_GAP - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             req_q_r;
    logic             se_use_s;
    logic             req_use_s;
    logic             wrst_edge_s;
    logic             rst_l_nxt_s;
    logic             adbg_nxt_s;
    logic             done_nxt_s;
    logic             ack_nxt_s;

`ifdef CCX_RST_SYNC_EN
    logic [1:0] se_sync_r;
    logic [1:0] req_sync_r;

    // two-flop synchronizers for the asynchronous test/request inputs
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            se_sync_r  <= 2'b00;
            req_sync_r <= 2'b00;
        end else begin
            se_sync_r  <= {se_sync_r[0], se_in};
            req_sync_r <= {req_sync_r[0], wrst_req};
        end
    end

    assign se_use_s  = se_sync_r[1];
    assign req_use_s = req_sync_r[1];
`else
    assign se_use_s  = se_in;
    assign req_use_s = wrst_req;
`endif

    assign wrst_edge_s = req_use_s & ~req_q_r;

    // next-state and sequenced-output logic; se_out freezes everything except the ack pulse
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        rst_l_nxt_s = rst_l_out;
        adbg_nxt_s  = adbginit_l_out;
        done_nxt_s  = rst_done;
        ack_nxt_s   = 1'b0;
        if (!se_out) begin
            case (state_r)
                ST_HOLD: begin
                    if (cnt_r == HOLD_LAST) begin
                        state_nxt_s = ST_DBG_REL;
                        cnt_nxt_s   = CNT_W'(0);
                        adbg_nxt_s  = 1'b1;
                    end else begin
                        cnt_nxt_s   = cnt_r + CNT_W'(1);
                    end
                end
                ST_DBG_REL: begin
                    if (cnt_r == GAP_LAST) begin
                        state_nxt_s = ST_RUN;
                        cnt_nxt_s   = CNT_W'(0);
                        rst_l_nxt_s = 1'b1;
                        done_nxt_s  = 1'b1;
                    end else begin
                        cnt_nxt_s   = cnt_r + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    // debug-init stays released across a warm reset
                    if (wrst_edge_s) begin
                        state_nxt_s = ST_WRST;
                        cnt_nxt_s   = CNT_W'(0);
                        rst_l_nxt_s = 1'b0;
                        done_nxt_s  = 1'b0;
                    end else begin
                        cnt_nxt_s   = CNT_W'(0);
                    end
                end
                ST_WRST: begin
                    if (cnt_r == HOLD_LAST) begin
                        state_nxt_s = ST_RUN;
                        cnt_nxt_s   = CNT_W'(0);
                        rst_l_nxt_s = 1'b1;
                        done_nxt_s  = 1'b1;
                        ack_nxt_s   = 1'b1;
                    end else begin
                        cnt_nxt_s   = cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt_s = ST_HOLD;
                    cnt_nxt_s   = CNT_W'(0);
                    rst_l_nxt_s = 1'b0;
                    adbg_nxt_s  = 1'b0;
                    done_nxt_s  = 1'b0;
                end
            endcase
        end else begin
            ack_nxt_s = 1'b0;
        end
    end

    // state, counter, request history and all registered outputs
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_HOLD;
            cnt_r          <= CNT_W'(0);
            req_q_r        <= 1'b0;
            se_out         <= 1'b0;
            rst_l_out      <= 1'b0;
            adbginit_l_out <= 1'b0;
            rst_done       <= 1'b0;
            wrst_ack       <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            cnt_r          <= cnt_nxt_s;
            req_q_r        <= req_use_s;
            se_out         <= se_use_s;
            rst_l_out      <= rst_l_nxt_s;
            adbginit_l_out <= adbg_nxt_s;
            rst_done       <= done_nxt_s;
            wrst_ack       <= ack_nxt_s;
        end
    end

endmodule

// File: tb/tb_ccx_rst_seq_ctl.sv
// Directed self-checking bench for ccx_rst_seq_ctl (default and HOLD_CYC=1/DBG_GAP=1 instances).
module tb_ccx_rst_seq_ctl;

`ifdef CCX_RST_SYNC_EN
    localparam int WD = 2;
    localparam int SL = 3;
`else
    localparam int WD = 0;
    localparam int SL = 1;
`endif

    logic rclk;
    logic rst, se_in, wrst_req;
    logic rst_l_out, adbginit_l_out, se_out, rst_done, wrst_ack;
    logic rst_m, se_in_m, wrst_req_m;
    logic rst_l_m, adbg_m, se_out_m, done_m, ack_m;

    int n_cmp = 0;
    int n_bad = 0;

    // obs/exp packing: {adbginit_l, rst_l, rst_done, wrst_ack, se_out}
    logic [4:0] obs;
    logic [4:0] exp_v;

    ccx_rst_seq_ctl u_dut (
        .rclk(rclk), .rst(rst), .se_in(se_in), .wrst_req(wrst_req),
        .rst_l_out(rst_l_out), .adbginit_l_out(adbginit_l_out), .se_out(se_out),
        .rst_done(rst_done), .wrst_ack(wrst_ack)
    );

    ccx_rst_seq_ctl #(.HOLD_CYC(1), .DBG_GAP(1), .CNT_W(2)) u_min (
        .rclk(rclk), .rst(rst_m), .se_in(se_in_m), .wrst_req(wrst_req_m),
        .rst_l_out(rst_l_m), .adbginit_l_out(adbg_m), .se_out(se_out_m),
        .rst_done(done_m), .wrst_ack(ack_m)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        obs = {adbginit_l_out, rst_l_out, rst_done, wrst_ack, se_out};
        n_cmp++;
        if (obs !== 5'b00000) begin
            n_bad++;
            $display("FAIL reset_initial: got %b want %b", obs, 5'b00000);
        end
        tick();
        tick();
        obs = {adbginit_l_out, rst_l_out, rst_done, wrst_ack, se_out};
        n_cmp++;
        if (obs !== 5'b00000) begin
            n_bad++;
            $display("FAIL reset_held: got %b want %b", obs, 5'b00000);
        end
    endtask

    // releases rst at posedge+1 and checks the full 16/20 cold sequence
    task automatic test_cold(input string tag);
        rst = 1'b0;
        for (int e = 1; e <= 23; e++) begin
            tick();
            exp_v = {e >= 16, e >= 20, e >= 20, 1'b0, 1'b0};
            obs   = {adbginit_l_out, rst_l_out, rst_done, wrst_ack, se_out};
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL %s edge %0d: got %b want %b", tag, e, obs, exp_v);
            end
        end
    endtask

    // mode 0: single pulse; 1: held high; 2: pulse plus re-pulse during WRST
    task automatic test_warm(input int mode, input string tag);
        logic in_w;
        for (int e = 1; e <= 30 + WD; e++) begin
            case (mode)
                0: wrst_req = (e == 1);
                1: wrst_req = (e <= 26 + WD);
                default: wrst_req = (e == 1) || (e == 6);
            endcase
            tick();
            in_w  = (e >= 1 + WD) && (e <= 16 + WD);
            exp_v = {1'b1, !in_w, !in_w, e == 17 + WD, 1'b0};
            obs   = {adbginit_l_out, rst_l_out, rst_done, wrst_ack, se_out};
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL %s edge %0d: got %b want %b", tag, e, obs, exp_v);
            end
        end
        wrst_req = 1'b0;
    endtask

    task automatic test_scan_freeze();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int e = 1; e <= 27; e++) begin
            se_in = (e >= 9) && (e <= 13);
            tick();
            exp_v = {e >= 21, e >= 25, e >= 25, 1'b0, (e >= 8 + SL) && (e <= 12 + SL)};
            obs   = {adbginit_l_out, rst_l_out, rst_done, wrst_ack, se_out};
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL scan_freeze edge %0d: got %b want %b", e, obs, exp_v);
            end
        end
        se_in = 1'b0;
    endtask

    task automatic test_mid_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int e = 1; e <= 17; e++) tick();
        n_cmp++;
        if ({adbginit_l_out, rst_l_out} !== 2'b10) begin
            n_bad++;
            $display("FAIL mid_dbg_rel_state: got %b want %b", {adbginit_l_out, rst_l_out}, 2'b10);
        end
        #2 rst = 1'b1;
        #1;
        obs = {adbginit_l_out, rst_l_out, rst_done, wrst_ack, se_out};
        n_cmp++;
        if (obs !== 5'b00000) begin
            n_bad++;
            $display("FAIL async_rst_dbg_rel: got %b want %b", obs, 5'b00000);
        end
        tick();
        test_cold("cold_after_dbg_rel");
        wrst_req = 1'b1;
        tick();
        wrst_req = 1'b0;
        for (int e = 2; e <= 6 + WD; e++) tick();
        obs = {adbginit_l_out, rst_l_out, rst_done, wrst_ack, se_out};
        n_cmp++;
        if (obs !== 5'b10000) begin
            n_bad++;
            $display("FAIL mid_wrst_state: got %b want %b", obs, 5'b10000);
        end
        #2 rst = 1'b1;
        #1;
        obs = {adbginit_l_out, rst_l_out, rst_done, wrst_ack, se_out};
        n_cmp++;
        if (obs !== 5'b00000) begin
            n_bad++;
            $display("FAIL async_rst_wrst: got %b want %b", obs, 5'b00000);
        end
        tick();
        test_cold("cold_after_wrst");
    endtask

    task automatic test_min_params();
        obs = {adbg_m, rst_l_m, done_m, ack_m, se_out_m};
        n_cmp++;
        if (obs !== 5'b00000) begin
            n_bad++;
            $display("FAIL min_reset: got %b want %b", obs, 5'b00000);
        end
        rst_m = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            exp_v = {e >= 1, e >= 2, e >= 2, 1'b0, 1'b0};
            obs   = {adbg_m, rst_l_m, done_m, ack_m, se_out_m};
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL min_cold edge %0d: got %b want %b", e, obs, exp_v);
            end
        end
        for (int e = 1; e <= 4 + WD; e++) begin
            wrst_req_m = (e == 1);
            tick();
            exp_v = {1'b1, e != 1 + WD, e != 1 + WD, e == 2 + WD, 1'b0};
            obs   = {adbg_m, rst_l_m, done_m, ack_m, se_out_m};
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL min_warm edge %0d: got %b want %b", e, obs, exp_v);
            end
        end
        wrst_req_m = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        se_in = 1'b0;
        wrst_req = 1'b0;
        rst_m = 1'b1;
        se_in_m = 1'b0;
        wrst_req_m = 1'b0;
        test_reset();
        test_cold("cold");
        test_warm(0, "warm_pulse");
        test_warm(1, "warm_held");
        tick();
        tick();
        test_warm(2, "warm_repulse");
        test_scan_freeze();
        test_mid_reset();
        test_min_params();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
